// File: rtl/link_sched_pkg.sv
// Shared types and constants for the UART link scheduler.
// Contents: FSM/beacon encodings, mode codes, frame layout, moving-source selector.
package link_sched_pkg;

    localparam int unsigned MOVE_W  = 4;
    localparam int unsigned DET_W   = 4;
    localparam int unsigned FRAME_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_WAIT = 2'd3
    } sched_state_t;

    typedef enum logic [1:0] {
        BCN_NONE    = 2'd0,
        BCN_PLACE   = 2'd1,
        BCN_DESTROY = 2'd2
    } bcn_kind_t;

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_SEMI_A = 2'b01;
    localparam logic [1:0] MODE_SEMI_B = 2'b10;
    localparam logic [1:0] MODE_AUTO   = 2'b11;

    localparam logic [1:0]         FRAME_HDR    = 2'b10;
    localparam logic [DET_W-1:0]   DET_FAILSAFE = 4'b1111;
    localparam logic [FRAME_W-1:0] FRAME_RESET  = 8'h80;

    // Frame byte sent to the car: {hdr, destroy, place, moving}
    typedef struct packed {
        logic [1:0]        hdr;
        logic              de;
        logic              pl;
        logic [MOVE_W-1:0] moving;
    } frame_t;

    // Moving request owned by the current mode; engine off forces a stop
    function automatic logic [MOVE_W-1:0] select_moving(
        input logic [1:0]        gs,
        input logic              power,
        input logic [MOVE_W-1:0] mv_manual,
        input logic [MOVE_W-1:0] mv_semi,
        input logic [MOVE_W-1:0] mv_auto
    );
        logic [MOVE_W-1:0] mv;
        case (gs)
            MODE_MANUAL:              mv = mv_manual;
            MODE_SEMI_A, MODE_SEMI_B: mv = mv_semi;
            MODE_AUTO:                mv = mv_auto;
            default:                  mv = '0;
        endcase
        return power ? mv : '0;
    endfunction

endpackage

// File: rtl/link_sched_beacon.sv
// Beacon place/destroy request tracker: pending flags, one active kind, hold count.
// Ports: clk, rst_n, enable (auto mode; low discards pending), frame_load (LOAD cycle),
//        frame_sent (byte handshake), pl_req/de_req pulses, pl_bit_c/de_bit_c
//        (bits for the frame being built), busy (registered: active or pending).
module link_sched_beacon
    import link_sched_pkg::*;
#(
    parameter int unsigned HOLD_FRAMES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic frame_load,
    input  logic frame_sent,
    input  logic pl_req,
    input  logic de_req,
    output logic pl_bit_c,
    output logic de_bit_c,
    output logic busy
);

    localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);

    bcn_kind_t         kind_q, kind_ld, kind_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              pl_pend_q, pl_pend_d;
    logic              de_pend_q, de_pend_d;

    // Load promotes pending to active (place has priority), send counts down
    always_comb begin
        kind_ld   = kind_q;
        hold_d    = hold_q;
        pl_pend_d = pl_pend_q;
        de_pend_d = de_pend_q;

        if (frame_load) begin
            if (pl_pend_q && (kind_q != BCN_DESTROY)) begin
                kind_ld   = BCN_PLACE;
                hold_d    = HOLD_W'(HOLD_FRAMES);
                pl_pend_d = 1'b0;
            end else if (de_pend_q && (kind_q != BCN_PLACE)) begin
                kind_ld   = BCN_DESTROY;
                hold_d    = HOLD_W'(HOLD_FRAMES);
                de_pend_d = 1'b0;
            end
        end

        kind_d = kind_ld;
        if (frame_sent && (kind_ld != BCN_NONE)) begin
            if (hold_d <= HOLD_W'(1)) begin
                kind_d = BCN_NONE;
                hold_d = '0;
            end else begin
                hold_d = hold_d - HOLD_W'(1);
            end
        end

        // New pulses land after the load decision so they wait for the next frame
        if (enable) begin
            pl_pend_d = pl_pend_d | pl_req;
            de_pend_d = de_pend_d | de_req;
        end else begin
            pl_pend_d = 1'b0;
            de_pend_d = 1'b0;
        end
    end

    assign pl_bit_c = (kind_ld == BCN_PLACE);
    assign de_bit_c = (kind_ld == BCN_DESTROY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind_q    <= BCN_NONE;
            hold_q    <= '0;
            pl_pend_q <= 1'b0;
            de_pend_q <= 1'b0;
            busy      <= 1'b0;
        end else begin
            kind_q    <= kind_d;
            hold_q    <= hold_d;
            pl_pend_q <= pl_pend_d;
            de_pend_q <= de_pend_d;
            busy      <= (kind_d != BCN_NONE) | pl_pend_d | de_pend_d;
        end
    end

endmodule

// File: rtl/link_scheduler.sv
// UART link sequencer to the simulated car: one frame per period, reply capture, watchdog.
// Ports: sys_clk, rst_n, global_state, power, mv_manual/semi/auto, pl/de_beacon_req,
//        tx_data/tx_valid/tx_ready (UART tx handshake), rx_data/rx_valid (replies),
//        detector, link_ok, beacon_busy.
// Option: LINK_SCHED_EARLY_TX_EN sends a changed moving value early after MIN_GAP_CYC.
module link_scheduler
    import link_sched_pkg::*;
#(
    parameter int unsigned FRAME_PERIOD_CYC   = 100_000,
    parameter int unsigned BEACON_HOLD_FRAMES = 4,
    parameter int unsigned RX_TIMEOUT_FRAMES  = 8,
    parameter int unsigned MIN_GAP_CYC        = 16
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic [1:0]         global_state,
    input  logic               power,
    input  logic [MOVE_W-1:0]  mv_manual,
    input  logic [MOVE_W-1:0]  mv_semi,
    input  logic [MOVE_W-1:0]  mv_auto,
    input  logic               pl_beacon_req,
    input  logic               de_beacon_req,
    output logic [FRAME_W-1:0] tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [DET_W-1:0]   detector,
    output logic               link_ok,
    output logic               beacon_busy
);

    localparam int unsigned PER_W = $clog2(FRAME_PERIOD_CYC);
    localparam int unsigned WD_W  = $clog2(RX_TIMEOUT_FRAMES + 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(FRAME_PERIOD_CYC - 1);

    sched_state_t       state_q, state_d;
    logic [PER_W-1:0]   per_q, per_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [FRAME_W-1:0] tx_data_d;
    logic               tx_valid_d;
    logic [DET_W-1:0]   detector_d;
    logic               link_ok_d;
    logic [MOVE_W-1:0]  sel_mv_c;
    logic               frame_load_c;
    logic               handshake_c;
    logic               auto_c;
    logic               pl_bit_c, de_bit_c;
    frame_t             frame_c;
    logic               unused_rx_hi;

`ifdef LINK_SCHED_EARLY_TX_EN
    localparam int unsigned GAP_W = $clog2(MIN_GAP_CYC + 1);
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [MOVE_W-1:0] last_mv_q, last_mv_d;
`else
    localparam int unsigned unused_min_gap = MIN_GAP_CYC;
`endif

    assign unused_rx_hi = ^rx_data[7:4];
    assign sel_mv_c     = select_moving(global_state, power, mv_manual, mv_semi, mv_auto);
    assign frame_load_c = (state_q == ST_LOAD);
    assign handshake_c  = tx_valid & tx_ready;
    assign auto_c       = (global_state == MODE_AUTO);

    link_sched_beacon #(
        .HOLD_FRAMES (BEACON_HOLD_FRAMES)
    ) u_beacon (
        .clk        (sys_clk),
        .rst_n      (rst_n),
        .enable     (auto_c),
        .frame_load (frame_load_c),
        .frame_sent (handshake_c),
        .pl_req     (pl_beacon_req),
        .de_req     (de_beacon_req),
        .pl_bit_c   (pl_bit_c),
        .de_bit_c   (de_bit_c),
        .busy       (beacon_busy)
    );

    // Next-state, frame build, period counter and reply watchdog
    always_comb begin
        state_d    = state_q;
        per_d      = (per_q >= PER_LAST) ? PER_LAST : per_q + PER_W'(1);
        wd_d       = wd_q;
        tx_data_d  = tx_data;
        tx_valid_d = tx_valid;
        detector_d = detector;
        link_ok_d  = link_ok;

        frame_c.hdr    = FRAME_HDR;
        frame_c.de     = auto_c & de_bit_c;
        frame_c.pl     = auto_c & pl_bit_c;
        frame_c.moving = sel_mv_c;

`ifdef LINK_SCHED_EARLY_TX_EN
        gap_d     = (gap_q >= GAP_W'(MIN_GAP_CYC)) ? gap_q : gap_q + GAP_W'(1);
        last_mv_d = last_mv_q;
        if (handshake_c) begin
            gap_d = GAP_W'(1);
        end
        if (frame_load_c) begin
            last_mv_d = sel_mv_c;
        end
`endif

        case (state_q)
            ST_IDLE: state_d = ST_LOAD;
            ST_LOAD: begin
                tx_data_d  = frame_c;
                tx_valid_d = 1'b1;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    // A late handshake starts the next frame right away
                    state_d    = (per_q >= PER_LAST) ? ST_LOAD : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (per_q >= PER_LAST) begin
                    state_d = ST_LOAD;
                end
`ifdef LINK_SCHED_EARLY_TX_EN
                else if ((sel_mv_c != last_mv_q) && (gap_q >= GAP_W'(MIN_GAP_CYC))) begin
                    state_d = ST_LOAD;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        // Period is measured from the LOAD cycle (count 0)
        if (state_d == ST_LOAD) begin
            per_d = '0;
        end

        // A reply on the timeout cycle keeps the link up
        if (rx_valid) begin
            detector_d = rx_data[DET_W-1:0];
            link_ok_d  = 1'b1;
            wd_d       = '0;
        end else if (frame_load_c) begin
            if (wd_q >= WD_W'(RX_TIMEOUT_FRAMES - 1)) begin
                wd_d       = WD_W'(RX_TIMEOUT_FRAMES);
                link_ok_d  = 1'b0;
                detector_d = DET_FAILSAFE;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            per_q     <= '0;
            wd_q      <= '0;
            tx_data   <= FRAME_RESET;
            tx_valid  <= 1'b0;
            detector  <= DET_FAILSAFE;
            link_ok   <= 1'b0;
`ifdef LINK_SCHED_EARLY_TX_EN
            gap_q     <= '0;
            last_mv_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            per_q     <= per_d;
            wd_q      <= wd_d;
            tx_data   <= tx_data_d;
            tx_valid  <= tx_valid_d;
            detector  <= detector_d;
            link_ok   <= link_ok_d;
`ifdef LINK_SCHED_EARLY_TX_EN
            gap_q     <= gap_d;
            last_mv_q <= last_mv_d;
`endif
        end
    end

endmodule
